numlock_code_sender: RTL and testbench
======================================

Name: numlock_code_sender

Overview:
Transmitter counterpart to the number-lock state machine. It takes a binary combination and plays it out as a sequence of discrete button presses on U (bit=1) and Z (bit=0), releasing both buttons between presses as the lock's "get"/release states require. It then watches the lock's Unlock output and reports success or timeout. It sits beside the lock in the lab top level, as an automated code-entry driver and self-check source.

Parameters:
CODE_LEN, 4, number of code bits (presses); range 1..16
PULSE_CYCLES, 2, clocks each press is held; must be ≥1
GAP_CYCLES, 1, clocks both buttons are released after each press; must be ≥1
TIMEOUT_CYCLES, 8, clocks to wait for Unlock after the last release; must be ≥1

Ports:
Clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Start  in  1  request to send; sampled only in IDLE
Code_in  in  CODE_LEN  combination, MSB sent first; latched on accepted Start
Unlock  in  1  lock's Unlock output, same clock domain, no synchronizer
U  out  1  "1" button press
Z  out  1  "0" button press
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse at end of attempt
Success  out  1  result; valid while Done=1, held until next accepted Start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, U=Z=0, Busy=0, Done=0, Success=0, index and counters cleared. Reset mid-sequence aborts immediately. No pulse is emitted on deassertion.
- All outputs are registered. U and Z are never 1 in the same cycle.
- States are IDLE, PRESS, RELEASE, WAIT_UNLOCK and DONE.
- IDLE:
  - Start=1 latches Code_in, sets idx=CODE_LEN-1, clears Success, and enters PRESS next cycle.
  - Start=0 stays in IDLE.
- PRESS:
  - U=code[idx], Z=~code[idx] for exactly PULSE_CYCLES clocks, then RELEASE.
  - The first press appears on the cycle after Start is sampled (1-cycle latency).
- RELEASE:
  - U=Z=0 for exactly GAP_CYCLES clocks.
  - Then, if idx==0, enter WAIT_UNLOCK; otherwise idx decrements and the block enters PRESS.
- WAIT_UNLOCK:
  - U=Z=0.
  - Unlock=1 in any of TIMEOUT_CYCLES cycles enters DONE with Success=1.
  - If the count expires without Unlock, enter DONE with Success=0.
  - Unlock is ignored in all other states, including assertion during PRESS/RELEASE.
- DONE:
  - Done=1 for one cycle, Busy=1, then IDLE.
  - Start in DONE is ignored.
- Start while Busy=1 is ignored and has no queueing. Code_in changes after acceptance have no effect.
- Total press-phase length is CODE_LEN*(PULSE_CYCLES+GAP_CYCLES) clocks.
- One shared down-counter serves pulse, gap and timeout. It loads N-1 on state entry, and the state exits when it reaches 0 (no wrap).

Optional Feature:
NUMLOCK_SENDER_ABORT_EN
- Defined: adds input Abort (1 bit). Abort=1 in PRESS, RELEASE or WAIT_UNLOCK forces U=Z=0 next cycle and enters DONE with Success=0. Abort has priority over a simultaneous Unlock. Abort in IDLE or DONE has no effect.
- Undefined: the port is absent, and the behaviour is exactly as specified above.

Decomposition:
- Shared package/include numlock_defs: state encoding constants (IDLE, PRESS, RELEASE, WAIT_UNLOCK, DONE), default code constant 4'b1011 matching the lock's hard-wired combination, and default timing constants.
- One sub-module, numlock_tick_counter: loadable down-counter with load value, load strobe and zero flag; width from clog2 of the maximum of the three timing parameters.
- The FSM, index register and output registers stay in numlock_code_sender.

Test Plan:
- Defaults, Code_in=4'b1011, Start pulsed one cycle, Unlock tied 0 → U/Z per cycle after Start: U,U,0,0-gap,Z,Z,gap,U,U,gap,U,U,gap. Then 8 WAIT cycles, Done=1 with Success=0. Busy high for 12+8+1 cycles.
- Same code, Unlock=1 on the 3rd WAIT_UNLOCK cycle → Done pulses the next cycle with Success=1. U=Z=0 throughout WAIT.
- Unlock=1 forced during PRESS of bit 2 and dropped before WAIT_UNLOCK → ignored; ends in timeout with Success=0.
- Start re-pulsed mid-sequence with Code_in=4'b0000 → sequence continues emitting 1011 unchanged; no second attempt after Done.
- reset driven low during the second RELEASE, asynchronous to Clk → U=Z=Busy=Done=0 immediately. After release, a fresh Start replays from the MSB.
- NUMLOCK_SENDER_ABORT_EN defined: Abort=1 during the third PRESS with Unlock=1 simultaneously → U=Z=0 next cycle, Done pulse with Success=0.

Source files
------------

// File: rtl/numlock_code_sender_pkg.sv
// Shared definitions for the number-lock code sender: state encoding,
// default lock combination and default press/gap/timeout timing.
package numlock_code_sender_pkg;

  // Sender states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE,
    ST_WAIT_UNLOCK,
    ST_DONE
  } state_t;

  // Matches the lock's hard-wired combination
  localparam int unsigned DEF_CODE_LEN       = 4;
  localparam logic [3:0]  DEF_CODE           = 4'b1011;
  localparam int unsigned DEF_PULSE_CYCLES   = 2;
  localparam int unsigned DEF_GAP_CYCLES     = 1;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 8;

  // Counter width able to hold the largest (N-1) load value; never below 1 bit
  function automatic int unsigned cnt_width(input int unsigned p,
                                            input int unsigned g,
                                            input int unsigned t);
    int unsigned m;
    m = p;
    if (g > m) m = g;
    if (t > m) m = t;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/numlock_code_sender_tick_counter.sv
// Loadable down-counter shared by the pulse, gap and timeout phases.
// Counts down to zero and holds there; a load overrides counting.
module numlock_tick_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load on strobe, otherwise decrement until zero (no wrap)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/numlock_code_sender.sv
// Number-lock code sender: plays a latched combination MSB-first as
// discrete U (1) / Z (0) presses separated by releases, then waits for
// the lock's Unlock and reports Success with a one-cycle Done pulse.
// Optional feature macro: NUMLOCK_SENDER_ABORT_EN adds an Abort input.
module numlock_code_sender
  import numlock_code_sender_pkg::*;
#(
  parameter int unsigned CODE_LEN       = DEF_CODE_LEN,
  parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                Start,
  input  logic [CODE_LEN-1:0] Code_in,
  input  logic                Unlock,
`ifdef NUMLOCK_SENDER_ABORT_EN
  input  logic                Abort,
`endif
  output logic                U,
  output logic                Z,
  output logic                Busy,
  output logic                Done,
  output logic                Success
);

  localparam int unsigned CW = cnt_width(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [CW-1:0] LD_PULSE   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LD_GAP     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LD_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic [CODE_LEN-1:0] r_code;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_dec;
  logic                w_zero;
  logic                w_load;
  logic [CW-1:0]       w_load_val;
  logic                w_abort;

`ifdef NUMLOCK_SENDER_ABORT_EN
  assign w_abort = Abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_idx_dec = r_idx - 1'b1;

  numlock_tick_counter #(
    .WIDTH (CW)
  ) u_tick (
    .i_clk      (Clk),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Counter is reloaded on every transition into a timed state. An abort
  // may coincide with a load; the stale count is harmless since IDLE
  // always reloads on the next Start.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load     = 1'b1;
          w_load_val = LD_PULSE;
        end
      end
      ST_PRESS: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = LD_GAP;
        end
      end
      ST_RELEASE: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = (r_idx == '0) ? LD_TIMEOUT : LD_PULSE;
        end
      end
      default: ;
    endcase
  end

  // Sender FSM with registered button, status and result outputs
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_idx   <= '0;
      U       <= 1'b0;
      Z       <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Success <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_code  <= Code_in;
            r_idx   <= IW'(CODE_LEN - 1);
            Success <= 1'b0;
            Busy    <= 1'b1;
            U       <= Code_in[CODE_LEN-1];
            Z       <= ~Code_in[CODE_LEN-1];
            r_state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (w_abort) begin
            U       <= 1'b0;
            Z       <= 1'b0;
            Done    <= 1'b1;
            Success <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_zero) begin
            U       <= 1'b0;
            Z       <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_abort) begin
            Done    <= 1'b1;
            Success <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_zero) begin
            if (r_idx == '0) begin
              r_state <= ST_WAIT_UNLOCK;
            end else begin
              r_idx   <= w_idx_dec;
              U       <= r_code[w_idx_dec];
              Z       <= ~r_code[w_idx_dec];
              r_state <= ST_PRESS;
            end
          end
        end
        ST_WAIT_UNLOCK: begin
          if (w_abort) begin
            Done    <= 1'b1;
            Success <= 1'b0;
            r_state <= ST_DONE;
          end else if (Unlock) begin
            Done    <= 1'b1;
            Success <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_zero) begin
            Done    <= 1'b1;
            Success <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          Busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          U       <= 1'b0;
          Z       <= 1'b0;
          Busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_numlock_code_sender.sv
// Directed, table-driven bench for numlock_code_sender at default parameters.
module tb_numlock_code_sender;

  logic       Clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       Start   = 1'b0;
  logic       Unlock  = 1'b0;
  logic       Abort   = 1'b0;
  logic [3:0] Code_in = '0;
  logic       U, Z, Busy, Done, Success;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // One row: inputs driven during cycle c, outputs expected in cycle c+1.
  // exp packs {U, Z, Busy, Done, Success}.
  typedef struct {
    logic       start;
    logic [3:0] code;
    logic       unlock;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Hand-derived {U,Z} for code 1011, cycles 1..12 after Start
  logic [1:0] uz_1011 [12] = '{2'b10, 2'b10, 2'b00,
                               2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b00,
                               2'b10, 2'b10, 2'b00};

  always #5 Clk = ~Clk;

  numlock_code_sender #(
    .CODE_LEN       (4),
    .PULSE_CYCLES   (2),
    .GAP_CYCLES     (1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .Clk     (Clk),
    .reset   (reset),
    .Start   (Start),
    .Code_in (Code_in),
    .Unlock  (Unlock),
`ifdef NUMLOCK_SENDER_ABORT_EN
    .Abort   (Abort),
`endif
    .U       (U),
    .Z       (Z),
    .Busy    (Busy),
    .Done    (Done),
    .Success (Success)
  );

  task automatic check(input string name, input logic [4:0] exp);
    n_total++;
    if ({U, Z, Busy, Done, Success} === exp) n_pass++;
    else $display("FAIL %s: got UZBDS=%b expected %b", name,
                  {U, Z, Busy, Done, Success}, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Build rows for one 1011 attempt. unlock_cyc: cycle with a genuine
  // Unlock in WAIT (0 = never). noise_lo..noise_hi: Unlock held outside
  // WAIT. r1/r2: extra Start pulses (Code_in=0000) while busy.
  task automatic add_attempt(input int unlock_cyc, input int noise_lo,
                             input int noise_hi, input int r1, input int r2);
    int   done_cyc;
    logic suc;
    vec_t v;
    vecs.delete();
    done_cyc = (unlock_cyc != 0) ? unlock_cyc + 1 : 21;
    suc      = (unlock_cyc != 0);
    for (int c = 0; c <= done_cyc; c++) begin
      int k;
      k        = c + 1;
      v.start  = (c == 0) || (c == r1) || (c == r2);
      v.code   = (c == 0) ? 4'b1011 : 4'b0000;
      v.unlock = (c == unlock_cyc && c != 0) || (c >= noise_lo && c <= noise_hi);
      if (k <= 12)            v.exp = {uz_1011[k-1], 3'b100};
      else if (k < done_cyc)  v.exp = 5'b00100;
      else if (k == done_cyc) v.exp = {4'b0011, suc};
      else                    v.exp = {4'b0000, suc};
      vecs.push_back(v);
    end
  endtask

  task automatic run_vecs(input string name);
    foreach (vecs[i]) begin
      Start   = vecs[i].start;
      Code_in = vecs[i].code;
      Unlock  = vecs[i].unlock;
      step();
      check($sformatf("%s[%0d]", name, i), vecs[i].exp);
    end
    Start  = 1'b0;
    Unlock = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_state", 5'b00000);
    reset = 1'b1;
    step();
    check("idle_after_reset", 5'b00000);

    // Timeout; re-Start mid-sequence and in DONE both ignored
    add_attempt(0, -1, -2, 5, 21);
    run_vecs("timeout_restart");

    // Unlock on 3rd WAIT cycle (cycle 15)
    add_attempt(15, -1, -2, -1, -1);
    run_vecs("unlock_wait3");

    // Unlock during bit-2 press, dropped before WAIT: ignored
    add_attempt(0, 4, 9, -1, -1);
    run_vecs("unlock_early");

    // Asynchronous reset during the second RELEASE (cycle 6)
    Start   = 1'b1;
    Code_in = 4'b1011;
    step();
    Start = 1'b0;
    repeat (5) step();
    check("pre_reset_release", 5'b00100);
    #2 reset = 1'b0;
    #1 check("async_reset", 5'b00000);
    step();
    check("held_in_reset", 5'b00000);
    reset = 1'b1;
    step();
    check("no_pulse_after_reset", 5'b00000);
    Start   = 1'b1;
    Code_in = 4'b0110;
    step();
    Start = 1'b0;
    check("replay_msb_c1", 5'b01100);
    step();
    check("replay_msb_c2", 5'b01100);
    step();
    check("replay_gap", 5'b00100);
    step();
    check("replay_bit2", 5'b10100);
    reset = 1'b0;
    #2 reset = 1'b1;
    step();

`ifdef NUMLOCK_SENDER_ABORT_EN
    // Abort with simultaneous Unlock during third press
    Start   = 1'b1;
    Code_in = 4'b1011;
    step();
    Start = 1'b0;
    repeat (6) step();
    check("abort_pre", 5'b10100);
    Abort  = 1'b1;
    Unlock = 1'b1;
    step();
    Abort  = 1'b0;
    Unlock = 1'b0;
    check("abort_done", 5'b00110);
    step();
    check("abort_idle", 5'b00000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
